load_store_unit: RTL
====================

# load_store_unit

Byte-addressed load/store front end placed between the execute stage and `data_memory`, which is word-addressed and writes only from the low bits of a word. It converts byte addresses to word addresses and extracts and sign- or zero-extends loaded bytes and halfwords. Sub-word stores at any lane are performed as read-modify-write with a full-word write to memory. A valid/ready request port and a valid/ready response port let the core stall on memory traffic.

## Interface
- `P_ADDR_WIDTH`, 11: word-address width of the attached data memory.
- `P_DATA_WIDTH`, 32: data width. Fixed at 32; other values are unsupported.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset. Asynchronous, active-low.
- `i_req_valid`  in  1  request present.
- `o_req_ready`  out  1  block can accept a request; high only in IDLE.
- `i_req_we`  in  1  1 = store, 0 = load.
- `i_req_addr`  in  32  byte address.
- `i_req_f3`  in  3  RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `i_req_wdata`  in  32  store data, right-aligned.
- `o_rsp_valid`  out  1  response present.
- `i_rsp_ready`  in  1  core consumes the response.
- `o_rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `o_rsp_err`  out  1  misaligned access (see Configuration).
- `o_mem_we`  out  1  memory write enable.
- `o_mem_addr`  out  P_ADDR_WIDTH  word address = latched `addr[P_ADDR_WIDTH+1:2]`. Upper address bits are ignored.
- `o_mem_f3`  out  3  constant 3'b010; the memory always sees full-word writes.
- `o_mem_wdata`  out  32  merged store word.
- `i_mem_rdata`  in  32  memory read data, combinational from `o_mem_addr`.

## Operation
- **Request latching:** a request is accepted when `i_req_valid && o_req_ready`. On acceptance, addr, we, f3 and wdata are latched. The memory-side outputs are driven from these latched values only.
- **States:** IDLE, LOAD, RMW_RD, WRITE, RESP.
- **IDLE:**
  - Misaligned request (trap enabled) → RESP with err.
  - Load → LOAD.
  - SW → WRITE.
  - SB/SH → RMW_RD.
- **LOAD:** capture `i_mem_rdata`, then select the lane with `addr[1:0]`:
  - LB: sign-extend byte.
  - LBU: zero-extend byte.
  - LH: sign-extend halfword at `addr[1]`.
  - LHU: zero-extend halfword at `addr[1]`.
  - LW: whole word.
  - Next state: RESP.
- **RMW_RD:** capture `i_mem_rdata` into the merge register.
  - SB replaces byte lane `addr[1:0]` with `wdata[7:0]`.
  - SH replaces halfword lane `addr[1]` with `wdata[15:0]`.
  - Next state: WRITE.
- **WRITE:** `o_mem_we`=1 for exactly one cycle, with `o_mem_wdata` = merged word (SW: `wdata` unchanged). Next state: RESP.
- **RESP:** `o_rsp_valid`=1, with rdata and err held stable until `i_rsp_ready`; then IDLE.
- **Unused funct3:** values 011, 110 and 111 are treated as LW/SW.
- **Output gating:** `o_mem_we` is decoded from state (WRITE only), never from request inputs.
- **Reset values:** all outputs are 0 during reset, except `o_mem_f3`=3'b010; state is IDLE. `o_req_ready` rises the first cycle after reset deasserts.
- **Reset mid-operation:** the FSM returns to IDLE immediately and `o_mem_we` drops asynchronously. An in-flight store is dropped. No response is issued for the aborted request.

## Timing
- Latency is counted from the accept edge N to the first cycle with `o_rsp_valid` high:
  - Load: N+2.
  - SW: N+2.
  - SB/SH: N+3.
  - Misaligned (trap): N+1.
- SB/SH: memory read at N+1, write at N+2. The read-to-write window is a single cycle; the core is stalled, so no other writer exists.
- No back-to-back acceptance. The next request can be accepted at the earliest on the cycle after the response handshake.
- `o_rsp_valid` never deasserts without `i_rsp_ready`.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined:** these accesses are misaligned:
  - LH/LHU/SH with `addr[0]`=1.
  - LW/SW with `addr[1:0]`≠0.
  - Response: `o_rsp_err`=1, rdata 0, no memory read or write.
- **Undefined:**
  - Low address bits are forced to alignment: bit 0 for halfword, bits 1:0 for word.
  - Every access proceeds normally.
  - `o_rsp_err` is tied 0.

## Test plan
- **LB sign-extend:** memory word 4 = 0x8899AABB; LB at 0x13 → rdata 0xFFFFFF88, valid at N+2, no write.
- **LBU, LHU:** same word; LBU 0x13 → 0x00000088; LHU 0x12 → 0x00008899.
- **SB read-modify-write:** SB addr 0x11, wdata 0x000000CC → one write at N+2 with addr 4, wdata 0x8899CCBB, f3 010; a subsequent LW 0x10 returns 0x8899CCBB.
- **Misaligned (trap defined):** LH 0x11 → err=1, rdata 0, valid at N+1, `o_mem_we` never high. Trap undefined: the same request returns the sign-extended halfword at 0x10 with err=0.
- **Response back-pressure:** `i_rsp_ready` held low for 3 cycles → valid, rdata and err stable and `o_req_ready` low; on the handshake, ready returns to 1 the next cycle.
- **Reset during WRITE:** assert `i_rst_n`=0 in the WRITE cycle of an SW → `o_mem_we` drops immediately, memory word is unchanged, and after release the block is IDLE with no response.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake bundle for load_store_unit.
// master = core / execute stage, slave = load_store_unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_f3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_f3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_f3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory; sub-word stores are RMW.
// Optional macro LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of force-aligning.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | ready for a request
// S_LOAD   | memory read in progress, extend loaded lane
// S_RMW_RD | read old word for a byte/halfword store, merge new lane
// S_WRITE  | single-cycle full-word write to memory
// S_RESP   | response held until the core takes it
module load_store_unit #(
    parameter int P_ADDR_WIDTH = 11,
    parameter int P_DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    load_store_unit_if.slave        bus,
    output logic                    o_mem_we,
    output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [2:0]              o_mem_f3,
    output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [P_DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } state_t;

    state_t                  state;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic [P_DATA_WIDTH-1:0] rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    mem_we_q;
    logic [P_ADDR_WIDTH-1:0] word_addr_q;
    logic [1:0]              lane_q;
    logic [2:0]              f3_q;
    logic [15:0]             wdata_q;
    logic [P_DATA_WIDTH-1:0] merge_q;

    logic                    req_is_word;
    logic                    req_is_half;
    logic                    req_misaligned;
    logic [P_ADDR_WIDTH+1:0] req_addr_al;
    logic                    unused_addr_hi;

    logic                    q_is_byte;
    logic                    q_is_half;
    logic [7:0]              rd_byte;
    logic [15:0]             rd_half;
    logic [P_DATA_WIDTH-1:0] load_ext;
    logic [P_DATA_WIDTH-1:0] merge_word;

    // funct3[1:0]: 00 byte, 01 half, 1x word (so 011/110/111 fall into word)
    assign req_is_word    = bus.req_f3[1];
    assign req_is_half    = (bus.req_f3[1:0] == 2'b01);
    assign unused_addr_hi = ^bus.req_addr[31:P_ADDR_WIDTH+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_misaligned = (req_is_half && bus.req_addr[0]) ||
                            (req_is_word && (bus.req_addr[1:0] != 2'b00));
    assign req_addr_al    = bus.req_addr[P_ADDR_WIDTH+1:0];
`else
    assign req_misaligned = 1'b0;
    always_comb begin
        req_addr_al = bus.req_addr[P_ADDR_WIDTH+1:0];
        if (req_is_word) begin
            req_addr_al[1:0] = 2'b00;
        end else if (req_is_half) begin
            req_addr_al[0] = 1'b0;
        end
    end
`endif

    assign q_is_byte = (f3_q[1:0] == 2'b00);
    assign q_is_half = (f3_q[1:0] == 2'b01);
    assign rd_byte   = i_mem_rdata[{lane_q, 3'b000} +: 8];
    assign rd_half   = i_mem_rdata[{lane_q[1], 4'b0000} +: 16];

    // f3_q[2] marks the unsigned loads (LBU/LHU)
    always_comb begin
        load_ext = i_mem_rdata;
        if (q_is_byte) begin
            load_ext = f3_q[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
        end else if (q_is_half) begin
            load_ext = f3_q[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
        end
    end

    always_comb begin
        merge_word = i_mem_rdata;
        if (q_is_byte) begin
            merge_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (q_is_half) begin
            merge_word[{lane_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            word_addr_q <= '0;
            lane_q      <= 2'b00;
            f3_q        <= 3'b000;
            wdata_q     <= '0;
            merge_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        word_addr_q <= req_addr_al[P_ADDR_WIDTH+1:2];
                        lane_q      <= req_addr_al[1:0];
                        f3_q        <= bus.req_f3;
                        wdata_q     <= bus.req_wdata[15:0];
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= req_misaligned;
                        if (req_misaligned) begin
                            rsp_valid_q <= 1'b1;
                            state       <= S_RESP;
                        end else if (!bus.req_we) begin
                            state <= S_LOAD;
                        end else if (req_is_word) begin
                            merge_q  <= bus.req_wdata;
                            mem_we_q <= 1'b1;
                            state    <= S_WRITE;
                        end else begin
                            state <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    rsp_rdata_q <= load_ext;
                    rsp_valid_q <= 1'b1;
                    state       <= S_RESP;
                end
                S_RMW_RD: begin
                    merge_q  <= merge_word;
                    mem_we_q <= 1'b1;
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    mem_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign o_mem_we      = mem_we_q;
    assign o_mem_addr    = word_addr_q;
    assign o_mem_f3      = 3'b010;
    assign o_mem_wdata   = merge_q;

endmodule
